// File: rtl/hamming12_decoder.sv
// hamming12_decoder: two-stage pipelined SEC decoder for 12-bit Hamming codewords.
// Optional build macro HAMMING_ERR_CNT_EN adds saturating corrected/uncorrectable
// word counters; without it the counter ports read zero and clr_counts is ignored.
module hamming12_decoder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [12:1]  in_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [8:1]   out_data,
    output logic [3:0]   out_syndrome,
    output logic         out_corrected,
    output logic         out_uncorr,
    input  logic         clr_counts,
    output logic [15:0]  corr_count,
    output logic [15:0]  uncorr_count
);

    localparam int unsigned CODE_W = 12;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYN_W  = 4;
    localparam int unsigned CNT_W  = 16;

    // Stage 1 registers
    logic              r_s1_valid;
    logic [CODE_W:1]   r_s1_code;

    // Output stage registers
    logic              r_out_valid;
    logic [DATA_W:1]   r_out_data;
    logic [SYN_W-1:0]  r_out_syndrome;
    logic              r_out_corrected;
    logic              r_out_uncorr;

    // Handshake / decode wires
    logic              w_out_free;
    logic              w_s1_adv;
    logic              w_accept;
    logic [SYN_W-1:0]  w_syn;
    logic [CODE_W:1]   w_flip;
    logic [CODE_W:1]   w_fixed;
    logic [DATA_W:1]   w_data;
    logic              w_corr;
    logic              w_uncorr;

    // Output slot can take a new word when empty or being drained this cycle
    assign w_out_free = !r_out_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_out_free;
    assign in_ready   = !r_s1_valid || w_out_free;
    assign w_accept   = in_valid && in_ready;

    // Even-parity syndrome {s8,s4,s2,s1} over the stage-1 codeword
    assign w_syn[0] = r_s1_code[1] ^ r_s1_code[3] ^ r_s1_code[5] ^ r_s1_code[7]
                    ^ r_s1_code[9] ^ r_s1_code[11];
    assign w_syn[1] = r_s1_code[2] ^ r_s1_code[3] ^ r_s1_code[6] ^ r_s1_code[7]
                    ^ r_s1_code[10] ^ r_s1_code[11];
    assign w_syn[2] = r_s1_code[4] ^ r_s1_code[5] ^ r_s1_code[6] ^ r_s1_code[7]
                    ^ r_s1_code[12];
    assign w_syn[3] = r_s1_code[8] ^ r_s1_code[9] ^ r_s1_code[10] ^ r_s1_code[11]
                    ^ r_s1_code[12];

    // One-hot flip mask from syndrome; 0 and 13-15 decode to no flip
    always_comb begin
        w_flip = '0;
        for (int i = 1; i <= 12; i++) begin
            if (w_syn == 4'(i)) begin
                w_flip[i] = 1'b1;
            end
        end
    end

    assign w_fixed  = r_s1_code ^ w_flip;
    assign w_data   = {w_fixed[12], w_fixed[11], w_fixed[10], w_fixed[9],
                       w_fixed[7],  w_fixed[6],  w_fixed[5],  w_fixed[3]};
    assign w_corr   = (w_syn != 4'd0) && (w_syn <= 4'd12);
    assign w_uncorr = (w_syn >= 4'd13);

    // Stage 1: capture accepted word, empty when it moves on with nothing behind it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_code  <= in_code;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Output stage: load decoded word, otherwise hold until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid     <= 1'b0;
            r_out_data      <= '0;
            r_out_syndrome  <= '0;
            r_out_corrected <= 1'b0;
            r_out_uncorr    <= 1'b0;
        end else if (w_s1_adv) begin
            r_out_valid     <= 1'b1;
            r_out_data      <= w_data;
            r_out_syndrome  <= w_syn;
            r_out_corrected <= w_corr;
            r_out_uncorr    <= w_uncorr;
        end else if (out_ready) begin
            r_out_valid     <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_syndrome  = r_out_syndrome;
    assign out_corrected = r_out_corrected;
    assign out_uncorr    = r_out_uncorr;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] r_corr_count;
    logic [CNT_W-1:0] r_uncorr_count;

    // Saturating error counters; clear takes priority over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_count   <= '0;
            r_uncorr_count <= '0;
        end else if (clr_counts) begin
            r_corr_count   <= '0;
            r_uncorr_count <= '0;
        end else if (w_s1_adv) begin
            if (w_corr && (r_corr_count != 16'hFFFF)) begin
                r_corr_count <= r_corr_count + 16'd1;
            end
            if (w_uncorr && (r_uncorr_count != 16'hFFFF)) begin
                r_uncorr_count <= r_uncorr_count + 16'd1;
            end
        end
    end

    assign corr_count   = r_corr_count;
    assign uncorr_count = r_uncorr_count;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_counts;
    assign corr_count   = '0;
    assign uncorr_count = '0;
`endif

endmodule

// File: tb/tb_hamming12_decoder.sv
// Directed bench for hamming12_decoder: decode cases, backpressure, counters, reset.
module tb_hamming12_decoder;

`ifdef HAMMING_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [12:1]  in_code;
    logic         out_valid;
    logic         out_ready;
    logic [8:1]   out_data;
    logic [3:0]   out_syndrome;
    logic         out_corrected;
    logic         out_uncorr;
    logic         clr_counts;
    logic [15:0]  corr_count;
    logic [15:0]  uncorr_count;

    int n_tests;
    int n_fail;

    hamming12_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_code       (in_code),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_syndrome  (out_syndrome),
        .out_corrected (out_corrected),
        .out_uncorr    (out_uncorr),
        .clr_counts    (clr_counts),
        .corr_count    (corr_count),
        .uncorr_count  (uncorr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counter expectation in the current build
    function automatic logic [15:0] cnt(input logic [15:0] v);
        return CNT_EN ? v : 16'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word with out_ready high and check it two edges later
    task automatic run_one(input string tag, input logic [11:0] code,
                           input logic [7:0] ed, input logic [3:0] es,
                           input logic ec, input logic eu,
                           input logic [15:0] ecc, input logic [15:0] euc);
        in_valid  = 1'b1;
        in_code   = code;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_lat"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_vld"},  32'(out_valid),     32'd1);
        check({tag, "_data"}, 32'(out_data),      32'(ed));
        check({tag, "_syn"},  32'(out_syndrome),  32'(es));
        check({tag, "_corr"}, 32'(out_corrected), 32'(ec));
        check({tag, "_unc"},  32'(out_uncorr),    32'(eu));
        check({tag, "_ccnt"}, 32'(corr_count),    32'(ecc));
        check({tag, "_ucnt"}, 32'(uncorr_count),  32'(euc));
        tick();
        check({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_code    = '0;
        out_ready  = 1'b0;
        clr_counts = 1'b0;
        tick();
        tick();
        check("rst_ovld", 32'(out_valid),     32'd0);
        check("rst_rdy",  32'(in_ready),      32'd1);
        check("rst_data", 32'(out_data),      32'd0);
        check("rst_syn",  32'(out_syndrome),  32'd0);
        check("rst_flg",  32'({out_corrected, out_uncorr}), 32'd0);
        check("rst_cnt",  32'({corr_count, uncorr_count}),  32'd0);
        rst_n = 1'b1;
        tick();

        // Decode cases
        run_one("clean",  12'hA27, 8'hA5, 4'd0,  1'b0, 1'b0, cnt(16'd0), cnt(16'd0));
        run_one("derr6",  12'hA07, 8'hA5, 4'd6,  1'b1, 1'b0, cnt(16'd1), cnt(16'd0));
        run_one("perr1",  12'hA26, 8'hA5, 4'd1,  1'b1, 1'b0, cnt(16'd2), cnt(16'd0));
        run_one("dbl",    12'h226, 8'h25, 4'd13, 1'b0, 1'b1, cnt(16'd2), cnt(16'd1));
        run_one("derr12", 12'h227, 8'hA5, 4'd12, 1'b1, 1'b0, cnt(16'd3), cnt(16'd1));
        run_one("zero",   12'h000, 8'h00, 4'd0,  1'b0, 1'b0, cnt(16'd3), cnt(16'd1));
        run_one("ones",   12'hF77, 8'hFF, 4'd0,  1'b0, 1'b0, cnt(16'd3), cnt(16'd1));

        // Backpressure: words 000, F77, 362, A27 -> 00, FF, 3C, A5
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 12'h000;
        check("bp_rdy0", 32'(in_ready), 32'd1);
        tick();
        in_code = 12'hF77;
        check("bp_rdy1", 32'(in_ready), 32'd1);
        tick();
        in_code = 12'h362;
        check("bp_full", 32'(in_ready), 32'd0);
        check("bp_hd0",  32'(out_data), 32'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_rdy",  32'(in_ready),  32'd0);
            check("bp_hold_vld",  32'(out_valid), 32'd1);
            check("bp_hold_data", 32'(out_data),  32'h00);
            check("bp_hold_syn",  32'(out_syndrome), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", 32'(in_ready), 32'd1);
        tick();
        in_code = 12'hA27;
        check("bp_w1", 32'(out_data),  32'hFF);
        check("bp_v1", 32'(out_valid), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_w2", 32'(out_data),  32'h3C);
        check("bp_v2", 32'(out_valid), 32'd1);
        tick();
        check("bp_w3", 32'(out_data),  32'hA5);
        check("bp_v3", 32'(out_valid), 32'd1);
        tick();
        check("bp_end", 32'(out_valid), 32'd0);

        // Counter clear
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        check("clr_c", 32'(corr_count),   32'd0);
        check("clr_u", 32'(uncorr_count), 32'd0);

`ifdef HAMMING_ERR_CNT_EN
        // Saturation: 65535 corrected words fill the counter, one more holds it
        in_valid  = 1'b1;
        in_code   = 12'hA07;
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        in_valid = 1'b0;
        tick();
        check("sat_fill", 32'(corr_count), 32'hFFFF);
        tick();
        run_one("sat", 12'hA07, 8'hA5, 4'd6, 1'b1, 1'b0, 16'hFFFF, 16'd0);
`endif

        // Clear coinciding with an increment: clear wins
        in_valid  = 1'b1;
        in_code   = 12'hA07;
        out_ready = 1'b1;
        tick();
        in_valid   = 1'b0;
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        check("clrinc_flag", 32'(out_corrected), 32'd1);
        check("clrinc_cnt",  32'(corr_count),    32'd0);
        tick();

        // Reset mid-stream discards in-flight words
        run_one("pre_rst", 12'h226, 8'h25, 4'd13, 1'b0, 1'b1, cnt(16'd0), cnt(16'd1));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 12'hF77;
        tick();
        in_code = 12'h362;
        tick();
        in_valid = 1'b0;
        check("mid_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_ovld", 32'(out_valid), 32'd0);
        check("mid_rdy",  32'(in_ready),  32'd1);
        check("mid_data", 32'(out_data),  32'd0);
        check("mid_cnt",  32'(uncorr_count), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check("post_rst_vld", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming12_decoder.md
# hamming12_decoder

Pipelined single-error-correcting decoder for the 12-bit Hamming codewords produced by `encoder`; it sits directly downstream of that block on the receive side. It accepts one codeword per cycle under valid/ready flow control, computes the 4-bit syndrome, corrects any single-bit error, flags uncorrectable syndromes, and delivers the recovered 8-bit data byte. Optional saturating error counters support link-quality monitoring.

## Interface
- No parameters; code geometry is fixed at 12 code bits and 8 data bits.
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Asynchronous active-low reset.
- in_valid  in  1  `in_code` is valid.
- in_ready  out  1  Block accepts `in_code` this cycle.
- in_code  in  [12:1]  Codeword: positions 1, 2, 4 and 8 are P1, P2, P4 and P8; positions 3, 5, 6, 7 are D1–D4; positions 9–12 are D5–D8.
- out_valid  out  1  Output word is valid.
- out_ready  in  1  Consumer accepts the output word.
- out_data  out  [8:1]  Corrected data byte.
- out_syndrome  out  [3:0]  Syndrome {s8,s4,s2,s1}.
- out_corrected  out  1  Syndrome is 1–12 and one bit was flipped.
- out_uncorr  out  1  Syndrome is 13–15 and no correction was made.
- clr_counts  in  1  Synchronous clear of both counters.
- corr_count  out  [15:0]  Count of corrected words, saturating.
- uncorr_count  out  [15:0]  Count of uncorrectable words, saturating.

## Operation
- Even parity throughout:
  - s1 = XOR of positions 1, 3, 5, 7, 9, 11.
  - s2 = XOR of positions 2, 3, 6, 7, 10, 11.
  - s4 = XOR of positions 4, 5, 6, 7, 12.
  - s8 = XOR of positions 8–12.
- Syndrome 0: no error; data passes unchanged; both flags are 0.
- Syndrome 1–12: invert code bit at position = syndrome, then extract data; `out_corrected` = 1. This includes errors in parity bits, where the data is unchanged but the flag is still set.
- Syndrome 13–15: extract raw data with no flip; `out_uncorr` = 1.
- Two-register pipeline:
  - Stage 1 (S1) holds the input codeword and its valid bit.
  - Stage 2 (OUT) holds the decoded data, syndrome, flags and `out_valid`.
- Input handshake: a word is accepted when `in_valid && in_ready`.
  - `in_ready` = !S1.valid || !out_valid || out_ready (combinational).
- S1 advances into OUT when S1.valid && (!out_valid || out_ready).
- When OUT is consumed and S1 is empty, `out_valid` drops to 0.
- Ordering is strictly FIFO; no word is dropped or duplicated.
- Output stability: while `out_valid && !out_ready`, all `out_*` signals hold constant.
- Counters update on the cycle a word loads into OUT:
  - `corr_count` +1 if that word's syndrome is 1–12.
  - `uncorr_count` +1 if that word's syndrome is 13–15.
  - Both saturate at 16'hFFFF.
- `clr_counts` zeroes both counters; if an increment coincides, the clear wins and the increment is lost.

## Timing
- Reset (async assert, sync release):
  - S1.valid = 0, `out_valid` = 0.
  - `out_data` = 0, `out_syndrome` = 0, `out_corrected` = 0, `out_uncorr` = 0.
  - Both counters = 0.
  - `in_ready` = 1 after reset.
- Latency: a word accepted at edge N is presented with `out_valid` = 1 after edge N+1 (2-cycle latency).
- Throughput: 1 word/cycle with `out_ready` held at 1.
- Full condition: S1 and OUT both valid with `out_ready` = 0 gives `in_ready` = 0.
- Simultaneous accept and drain while full is allowed: S1 moves to OUT while the new word enters S1.
- Reset mid-stream discards all in-flight words. Counters also clear.
- Syndrome and correction logic is combinational between S1 and OUT, one XOR tree plus a 4-to-12 decode.

## Configuration
- `HAMMING_ERR_CNT_EN` defined: counters and `clr_counts` are implemented as above.
- `HAMMING_ERR_CNT_EN` undefined:
  - No counter registers are built.
  - `corr_count` and `uncorr_count` are tied to 16'h0.
  - `clr_counts` is ignored.
  - Ports remain present so the interface is identical in both builds.

## Test plan
- Clean word: in_code = 12'hA27 with out_ready = 1 → two cycles later out_data = 8'hA5, syndrome 0, both flags 0.
- Data-bit error: in_code = 12'hA07 (bit 6 flipped) → out_data = 8'hA5, syndrome 6, out_corrected = 1, corr_count = 1.
- Parity-bit error: in_code = 12'hA26 (bit 1 flipped) → out_data = 8'hA5, syndrome 1, out_corrected = 1.
- Double error: in_code = 12'h226 (bits 12 and 1 flipped) → syndrome 13, out_uncorr = 1, out_data = 8'h25, uncorr_count +1.
- Backpressure: stream 4 words with out_ready = 0 → in_ready falls after 2 accepts and outputs hold steady. Releasing out_ready delivers all 4 words in order, one per cycle.
- Counters (macro on): force corr_count to 16'hFFFF, then send a corrected word → the count stays at FFFF. Pulse clr_counts in the same cycle as an increment → the count reads 0. With the macro off, both counts read 0 throughout.
